// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the MIPS Avalon-MM memory responder.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

  // Bit positions inside the sticky err vector
  localparam int ERR_RW_BOTH  = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_PROTOCOL = 2;
  localparam int ERR_W        = 3;

  // Wait-state counter bound; WAIT_CYCLES must lie in 1..MAX_WAIT
  localparam int MAX_WAIT   = 15;
  localparam int CNT_W      = 4;
  localparam int BYTE_LANES = 4;

endpackage

// File: rtl/avalon_byte_merge.sv
// Builds the word to be written back from the stored word, the bus write
// data and the per-lane byte enables.
module avalon_byte_merge
  import mips_avalon_pkg::*;
(
  input  logic [31:0]           old_word,
  input  logic [31:0]           writedata,
  input  logic [BYTE_LANES-1:0] byteenable,
  output logic [31:0]           merged
);

  // Replace only the enabled byte lanes, keep the rest of the stored word
  always_comb begin
    merged = old_word;
    for (int n = 0; n < BYTE_LANES; n++) begin
      if (byteenable[n]) merged[8*n +: 8] = writedata[8*n +: 8];
    end
  end

endmodule

// File: rtl/mips_avalon_mem_responder.sv
// Avalon-MM responder RAM for the MIPS CPU: fixed wait states per transfer,
// byte-enabled writes and sticky flags for master protocol violations.
module mips_avalon_mem_responder
  import mips_avalon_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [3:0]       byteenable,
  output logic             waitrequest,
  output logic [31:0]      readdata,
  output logic [ERR_W-1:0] err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("mips_avalon_mem_responder: WAIT_CYCLES must be within 1..15");
  end

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  resp_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Request register, loaded when a transfer is accepted in IDLE
  logic [31:0]      req_addr;
  logic [IDX_W-1:0] req_idx;
  logic             req_in_range;
  logic             req_read;
  logic             req_write;
  logic [31:0]      req_wdata;
  logic [3:0]       req_be;

  logic             capture, enter_ack, abort, commit, changed;
  logic [31:0]      offset;
  logic             bus_in_range;
  logic [IDX_W-1:0] bus_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range, rd_is_read;
  logic [31:0]      old_word, merged;
  logic             unused_addr_lsbs;

  // Word decode; the master always word-aligns so the two LSBs carry nothing
  assign offset           = address - BASE_ADDR;
  assign bus_idx          = offset[IDX_W+1:2];
  assign bus_in_range     = (address >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
  assign unused_addr_lsbs = ^offset[1:0];

  // In IDLE the transfer that enters ACK directly (WAIT_CYCLES==1) is still on
  // the bus; otherwise the captured request is authoritative.
  assign rd_idx      = (state == IDLE) ? bus_idx      : req_idx;
  assign rd_in_range = (state == IDLE) ? bus_in_range : req_in_range;
  assign rd_is_read  = (state == IDLE) ? read         : req_read;

  assign changed = !(read || write) || (address != req_addr) ||
                   (read != req_read) || (write != req_write) ||
                   (writedata != req_wdata) || (byteenable != req_be);

  assign waitrequest = (read || write) && (state != ACK);

  avalon_byte_merge u_merge (
    .old_word   (old_word),
    .writedata  (req_wdata),
    .byteenable (req_be),
    .merged     (merged)
  );

  // State and wait counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and transfer control strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    enter_ack = 1'b0;
    abort     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (read || write) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 1) begin
            state_nxt = ACK;
            enter_ack = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (changed) begin
          abort     = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          enter_ack = 1'b1;
          state_nxt = ACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
        // Read data was already presented on entry; a late change only blocks the write
        if (changed) abort = 1'b1;
        else         commit = req_write && !req_read && req_in_range;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request presented in IDLE
  always_ff @(posedge clk) begin
    if (capture) begin
      req_addr     <= address;
      req_idx      <= bus_idx;
      req_in_range <= bus_in_range;
      req_read     <= read;
      req_write    <= write;
      req_wdata    <= writedata;
      req_be       <= byteenable;
    end
  end

  // Single-port RAM: word fetched on entry to ACK, merged word written in ACK
  always_ff @(posedge clk) begin
    if (commit && !reset) mem[req_idx] <= merged;
    if (enter_ack)        old_word     <= mem[rd_idx];
  end

  // Read data holds until the next completed read; out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (enter_ack && rd_is_read) begin
      readdata <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

  // Sticky protocol and decode error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else begin
      if (capture && read && write)   err[ERR_RW_BOTH]  <= 1'b1;
      if (enter_ack && !rd_in_range)  err[ERR_RANGE]    <= 1'b1;
      if (abort)                      err[ERR_PROTOCOL] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_avalon_mem_responder.sv
// Scoreboard bench: three responders with WAIT_CYCLES 2, 1 and 3 share clk/reset.
module tb_mips_avalon_mem_responder;

  typedef struct {
    int          idx;
    int          wait_n;
    bit          chk_data;
    logic [31:0] data;
    logic [2:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address     [3];
  logic        read        [3];
  logic        write       [3];
  logic [31:0] writedata   [3];
  logic [3:0]  byteenable  [3];
  logic        waitrequest [3];
  logic [31:0] readdata    [3];
  logic [2:0]  err         [3];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mips_avalon_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(2), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
    .writedata(writedata[0]), .byteenable(byteenable[0]), .waitrequest(waitrequest[0]),
    .readdata(readdata[0]), .err(err[0]));

  mips_avalon_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
    .writedata(writedata[1]), .byteenable(byteenable[1]), .waitrequest(waitrequest[1]),
    .readdata(readdata[1]), .err(err[1]));

  mips_avalon_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(3), .INIT_FILE("")) dut2 (
    .clk(clk), .reset(reset), .address(address[2]), .read(read[2]), .write(write[2]),
    .writedata(writedata[2]), .byteenable(byteenable[2]), .waitrequest(waitrequest[2]),
    .readdata(readdata[2]), .err(err[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int k, input int wn, input bit cd, input logic [31:0] d, input logic [2:0] e);
    exp_t x;
    x.idx = k; x.wait_n = wn; x.chk_data = cd; x.data = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: on every completed transfer pop the oldest expectation and compare
  for (genvar g = 0; g < 3; g++) begin : g_mon
    int   wcnt = 0;
    exp_t e;
    always @(negedge clk) begin
      if (reset || !(read[g] || write[g])) begin
        wcnt = 0;
      end else if (waitrequest[g]) begin
        wcnt++;
      end else begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(g), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("ack_dut", 32'(g), 32'(e.idx));
          check("wait_cycles", 32'(wcnt), 32'(e.wait_n));
          if (e.chk_data) check("readdata", readdata[g], e.data);
          check("err", {29'b0, err[g]}, {29'b0, e.err});
        end
        wcnt = 0;
      end
    end
  end

  task automatic wait_ack(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitrequest[k] && n < 40);
    if (waitrequest[k]) check("ack_timeout", 32'(n), 32'd0);
  endtask

  // One complete transfer; entered and left at posedge+1
  task automatic xfer(input int k, input logic [31:0] a, input logic rd, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be, input int wn,
                      input bit cd, input logic [31:0] ed, input logic [2:0] ee);
    push(k, wn, cd, ed, ee);
    address[k] = a; read[k] = rd; write[k] = wr; writedata[k] = wd; byteenable[k] = be;
    wait_ack(k);
    @(posedge clk); #1;
    read[k] = 1'b0; write[k] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      address[k] = '0; read[k] = 1'b0; write[k] = 1'b0; writedata[k] = '0; byteenable[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_waitrequest", {31'b0, waitrequest[k]}, 32'd0);
      check("rst_readdata", readdata[k], 32'd0);
      check("rst_err", {29'b0, err[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // Boot word survives reset, then fetched with 2 wait states
    xfer(0, 32'hBFC00000, 0, 1, 32'h24020005, 4'hF, 2, 0, 0, 3'b000);
    do_reset();
    xfer(0, 32'hBFC00000, 1, 0, 32'h0, 4'hF, 2, 1, 32'h24020005, 3'b000);

    // Byte-enabled merge
    xfer(0, 32'hBFC00010, 0, 1, 32'h11223344, 4'b1111, 2, 0, 0, 3'b000);
    xfer(0, 32'hBFC00010, 0, 1, 32'hAABBCCDD, 4'b0101, 2, 0, 0, 3'b000);
    xfer(0, 32'hBFC00010, 1, 0, 32'h0, 4'hF, 2, 1, 32'h11BB33DD, 3'b000);
    xfer(0, 32'hBFC00010, 0, 1, 32'h99999999, 4'b0000, 2, 0, 0, 3'b000);
    xfer(0, 32'hBFC00010, 1, 0, 32'h0, 4'hF, 2, 1, 32'h11BB33DD, 3'b000);

    // Out-of-range halt fetch
    xfer(0, 32'h00000000, 1, 0, 32'h0, 4'hF, 2, 1, 32'h00000000, 3'b010);

    // read&write together is a read with no commit; err[0] sticky
    xfer(0, 32'hBFC00004, 0, 1, 32'hCAFEF00D, 4'hF, 2, 0, 0, 3'b010);
    xfer(0, 32'hBFC00004, 1, 1, 32'hDEADBEEF, 4'hF, 2, 1, 32'hCAFEF00D, 3'b011);
    xfer(0, 32'hBFC00004, 1, 0, 32'h0, 4'hF, 2, 1, 32'hCAFEF00D, 3'b011);

    // One past the end is dropped (would alias word 0); last word is in range
    xfer(0, 32'hBFC04000, 0, 1, 32'h12345678, 4'hF, 2, 0, 0, 3'b011);
    xfer(0, 32'hBFC03FFC, 1, 0, 32'h0, 4'hF, 2, 1, 32'h00000000, 3'b011);
    xfer(0, 32'hBFC00000, 1, 0, 32'h0, 4'hF, 2, 1, 32'h24020005, 3'b011);

    // Reset during WAIT of a write abandons it
    address[0] = 32'hBFC00020; write[0] = 1'b1; writedata[0] = 32'hFFFFFFFF; byteenable[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; write[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_waitrequest", {31'b0, waitrequest[0]}, 32'd0);
    check("mid_rst_err", {29'b0, err[0]}, 32'd0);
    check("mid_rst_readdata", readdata[0], 32'd0);
    @(posedge clk); #1;
    xfer(0, 32'hBFC00020, 1, 0, 32'h0, 4'hF, 2, 1, 32'h00000000, 3'b000);

    // WAIT_CYCLES=3: setup, then dropped read
    xfer(2, 32'hBFC00008, 0, 1, 32'h5A5A1234, 4'hF, 3, 0, 0, 3'b000);
    xfer(2, 32'hBFC00008, 1, 0, 32'h0, 4'hF, 3, 1, 32'h5A5A1234, 3'b000);
    address[2] = 32'hBFC0000C; read[2] = 1'b1;
    @(posedge clk); #1;
    read[2] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_err", {29'b0, err[2]}, 32'h4);
    check("drop_readdata", readdata[2], 32'h5A5A1234);
    check("drop_waitrequest", {31'b0, waitrequest[2]}, 32'd0);
    @(posedge clk); #1;

    // Address changed during WAIT: first transfer discarded, held request restarts
    push(2, 5, 0, 0, 3'b100);
    address[2] = 32'hBFC00008; write[2] = 1'b1; writedata[2] = 32'h77777777; byteenable[2] = 4'hF;
    @(posedge clk); #1;
    address[2] = 32'hBFC0000C;
    wait_ack(2);
    @(posedge clk); #1;
    write[2] = 1'b0;
    xfer(2, 32'hBFC00008, 1, 0, 32'h0, 4'hF, 3, 1, 32'h5A5A1234, 3'b100);
    xfer(2, 32'hBFC0000C, 1, 0, 32'h0, 4'hF, 3, 1, 32'h77777777, 3'b100);

    // WAIT_CYCLES=1 back-to-back fetches
    for (int i = 0; i < 4; i++)
      xfer(1, 32'hBFC00000 + 32'(4*i), 0, 1, 32'hA0000000 + 32'(i), 4'hF, 1, 0, 0, 3'b000);
    for (int i = 0; i < 4; i++) push(1, 1, 1, 32'hA0000000 + 32'(i), 3'b000);
    address[1] = 32'hBFC00000; read[1] = 1'b1;
    c0 = cyc;
    c1 = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1);
      if (i == 3) c1 = cyc;
      @(posedge clk); #1;
      if (i < 3) address[1] = 32'hBFC00000 + 32'(4*(i+1));
      else       read[1] = 1'b0;
    end
    check("burst_cycles", 32'(c1 - c0), 32'd7);

    repeat (2) @(posedge clk);
    check("leftover_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
